// File: rtl/mem_stage_mc_if.sv
// Request/response bundle between the pipeline and the multi-cycle memory stage.
interface mem_stage_mc_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] Addr;
  logic [WIDTH-1:0]  Write_data;
  logic              MemRead_cntrl;
  logic              MemWrite_cntrl;
  logic              Halt_cntrl;
  logic [WIDTH-1:0]  Read_data;
  logic              Stall;
  logic              Done;
  logic              Err;
  logic              Halted;

  modport master (
    output Addr, Write_data, MemRead_cntrl, MemWrite_cntrl, Halt_cntrl,
    input  Read_data, Stall, Done, Err, Halted
  );

  modport slave (
    input  Addr, Write_data, MemRead_cntrl, MemWrite_cntrl, Halt_cntrl,
    output Read_data, Stall, Done, Err, Halted
  );
endinterface

// File: rtl/mem_stage_mc.sv
// Multi-cycle data-memory stage: fixed-latency load/store with range fault and sticky halt.
// Optional MEM_ALIGN_CHECK_EN: misaligned byte addresses are faulted like out-of-range ones.
module mem_stage_mc #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_stage_mc_if.slave bus
);

  localparam int unsigned S      = (WIDTH == 32) ? 2 : 1;
  localparam int unsigned IDX_W  = ADDR_W - S;
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, HALT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic [WIDTH-1:0]   rdata_q;
  logic               is_wr_q;
  logic               err_q;
  logic               halt_pend_q;

  logic [WIDTH-1:0]   mem [DEPTH];

  logic               req;
  logic               accept;
  logic               enter_done;
  logic [ADDR_W-1:0]  acc_addr;
  logic               acc_wr;
  logic [IDX_W-1:0]   acc_idx;
  logic [MEM_AW-1:0]  rd_idx;
  logic [MEM_AW-1:0]  wr_idx;
  logic               misalign;
  logic               acc_fault;

  assign req = bus.MemRead_cntrl | bus.MemWrite_cntrl;

  // With LATENCY=1 the access resolves on the acceptance edge, so use live inputs in IDLE.
  assign acc_addr = (state_q == IDLE) ? bus.Addr : addr_q;
  assign acc_wr   = (state_q == IDLE) ? bus.MemWrite_cntrl : is_wr_q;
  assign acc_idx  = IDX_W'(acc_addr >> S);
  assign rd_idx   = MEM_AW'(acc_idx);
  assign wr_idx   = MEM_AW'(addr_q >> S);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = |acc_addr[S-1:0];
`else
  assign misalign = 1'b0;
`endif

  assign acc_fault = (32'(acc_idx) >= DEPTH) | misalign;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Halt_cntrl) begin
          state_d = HALT;
        end else if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d    = DONE;
            enter_done = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    state_d = (halt_pend_q || bus.Halt_cntrl) ? HALT : IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request, resolve read data and fault status on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_wr_q     <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= enter_done ? acc_fault : 1'b0;
      if (accept) begin
        addr_q  <= bus.Addr;
        wdata_q <= bus.Write_data;
        is_wr_q <= bus.MemWrite_cntrl;
      end
      if (enter_done && !acc_wr) begin
        rdata_q <= acc_fault ? '0 : mem[rd_idx];
      end
      if (state_q == DONE)                         halt_pend_q <= 1'b0;
      else if (state_q == BUSY && bus.Halt_cntrl) halt_pend_q <= 1'b1;
    end
  end

  // Storage is never reset; a store commits only on the edge leaving DONE.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DONE && is_wr_q && !err_q) begin
      mem[wr_idx] <= wdata_q;
    end
  end

  assign bus.Read_data = rdata_q;
  assign bus.Err       = err_q;
  assign bus.Done      = (state_q == DONE);
  assign bus.Halted    = (state_q == HALT);
  assign bus.Stall     = accept | (state_q == BUSY);

endmodule

// File: tb/tb_mem_stage_mc.sv
// Directed plus randomized bench for mem_stage_mc against an associative-array memory model.
module tb_mem_stage_mc;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned LAT    = 4;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] mdl [int];
  logic [15:0] last_rd;
  bit          last_known;

  mem_stage_mc_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mem_stage_mc #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.MemRead_cntrl  = 1'b0;
    bus.MemWrite_cntrl = 1'b0;
    bus.Halt_cntrl     = 1'b0;
    bus.Addr           = '0;
    bus.Write_data     = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_rd    = '0;
    last_known = 1'b1;
  endtask

  // One complete access with cycle-exact Stall/Done checks and model update.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int   idx;
    bit   fault;
    logic [15:0] exp_rd;
    bit   exp_known;
    idx   = int'(a >> 1);
    fault = (idx >= int'(DEPTH)) || (ALIGN && a[0]);
    if (!wr) begin
      exp_rd    = fault ? 16'h0 : (mdl.exists(idx) ? mdl[idx] : 16'h0);
      exp_known = fault || mdl.exists(idx);
    end else begin
      exp_rd    = last_rd;
      exp_known = last_known;
    end
    @(negedge clk);
    bus.MemRead_cntrl  = rd;
    bus.MemWrite_cntrl = wr;
    bus.Addr           = a;
    bus.Write_data     = d;
    #1 chk("stall_accept", bus.Stall, 1'b1);
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
      #1;
      chk("done_timing", bus.Done, (k == int'(LAT)));
      chk("stall_timing", bus.Stall, (k < int'(LAT)));
      if (k == int'(LAT)) begin
        chk("err", bus.Err, fault);
        if (exp_known) chk("read_data", bus.Read_data, exp_rd);
      end
    end
    @(negedge clk);
    #1 chk("done_pulse_end", bus.Done, 1'b0);
    if (wr && !fault) mdl[idx] = d;
    last_rd    = exp_rd;
    last_known = exp_known;
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    int          r;
    bit          rd;
    bit          wr;

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", bus.Done, 1'b0);
    chk("rst_err", bus.Err, 1'b0);
    chk("rst_halted", bus.Halted, 1'b0);
    chk("rst_stall", bus.Stall, 1'b0);
    chk("rst_rdata", bus.Read_data, 16'h0);
    @(negedge clk);
    rst        = 1'b0;
    last_rd    = '0;
    last_known = 1'b1;

    // Basic store then load.
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    access(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Simultaneous read+write behaves as a write.
    access(1'b1, 1'b1, 16'h0020, 16'h1234);
    access(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Out-of-range index aliases word 0 in storage but must not touch it.
    access(1'b0, 1'b1, 16'h0000, 16'h5A5A);
    access(1'b1, 1'b0, 16'h0800, 16'h0000);
    access(1'b0, 1'b1, 16'h0800, 16'hDEAD);
    access(1'b1, 1'b0, 16'h0000, 16'h0000);

    // Reset in the second BUSY cycle aborts the store.
    access(1'b0, 1'b1, 16'h0030, 16'h0A0A);
    @(negedge clk);
    bus.MemWrite_cntrl = 1'b1;
    bus.Addr           = 16'h0030;
    bus.Write_data     = 16'hFFFF;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1 chk("abort_no_done", bus.Done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_rd    = '0;
    last_known = 1'b1;
    for (int k = 0; k < int'(LAT); k++) begin
      #1 chk("abort_quiet", bus.Done, 1'b0);
      @(negedge clk);
    end
    chk("abort_rdata", bus.Read_data, 16'h0);
    access(1'b1, 1'b0, 16'h0030, 16'h0000);

    // Misaligned read: fault only with the alignment check enabled.
    access(1'b1, 1'b0, 16'h0011, 16'h0000);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) a = 16'h0800 + 16'($urandom_range(0, 30000));
      else        a = 16'(2 * $urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
      d  = 16'($urandom);
      r  = int'($urandom_range(0, 5));
      rd = (r != 0) && (r != 1);
      wr = (r <= 1) || (r == 5);
      access(rd, wr, a, d);
    end

    // Halt raised and dropped during BUSY: the load still completes, then halt sticks.
    @(negedge clk);
    bus.MemRead_cntrl = 1'b1;
    bus.Addr          = 16'h0010;
    #1 chk("halt_stall_accept", bus.Stall, 1'b1);
    for (int k = 1; k <= int'(LAT); k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
      if (k == 2) bus.Halt_cntrl = 1'b1;
      if (k == 3) bus.Halt_cntrl = 1'b0;
      #1;
      chk("halt_done_timing", bus.Done, (k == int'(LAT)));
      chk("halt_not_yet", bus.Halted, 1'b0);
      if (k == int'(LAT) && mdl.exists(8)) chk("halt_read_data", bus.Read_data, mdl[8]);
    end
    @(negedge clk);
    #1 chk("halted_set", bus.Halted, 1'b1);
    bus.MemRead_cntrl = 1'b1;
    bus.Addr          = 16'h0010;
    #1 chk("halted_stall", bus.Stall, 1'b0);
    for (int k = 0; k < int'(LAT) + 2; k++) begin
      @(negedge clk);
      #1;
      chk("halted_no_done", bus.Done, 1'b0);
      chk("halted_sticky", bus.Halted, 1'b1);
    end
    idle_inputs();
    pulse_reset();
    #1 chk("halt_cleared", bus.Halted, 1'b0);

    // Halt from IDLE blocks a simultaneous request.
    bus.Halt_cntrl    = 1'b1;
    bus.MemRead_cntrl = 1'b1;
    #1 chk("idle_halt_stall", bus.Stall, 1'b0);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("idle_halt_halted", bus.Halted, 1'b1);
    chk("idle_halt_done", bus.Done, 1'b0);
    pulse_reset();

    // Storage survives resets.
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    access(1'b1, 1'b0, 16'h0020, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage_mc.md
MEM_STAGE_MC -- requirements
Module: mem_stage_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits (16 or 32 only).
REQ-002 The block SHALL have parameter ADDR_W, default 16, byte-address width.
REQ-003 The block SHALL have parameter DEPTH, default 1024, storage words (power of two).
REQ-004 The block SHALL have parameter LATENCY, default 4, cycles from request acceptance to Done (1..15).
REQ-005 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port Addr  input  ADDR_W  byte address (ALU result).
REQ-008 The block SHALL have port Write_data  input  WIDTH  store data.
REQ-009 The block SHALL have port MemRead_cntrl  input  1  load request.
REQ-010 The block SHALL have port MemWrite_cntrl  input  1  store request.
REQ-011 The block SHALL have port Halt_cntrl  input  1  halt; blocks new requests.
REQ-012 The block SHALL have port Read_data  output  WIDTH  load result.
REQ-013 The block SHALL have port Stall  output  1  pipeline hold.
REQ-014 The block SHALL have port Done  output  1  one-cycle completion pulse.
REQ-015 The block SHALL have port Err  output  1  faulted-access flag, valid with Done.
REQ-016 The block SHALL have port Halted  output  1  sticky halt status.

Function
REQ-017 Word index SHALL be Addr >> S, where S = 1 (WIDTH 16) or 2 (WIDTH 32).
REQ-018 FSM states SHALL be IDLE, BUSY, DONE, HALT.
REQ-019 IDLE with request (Rd|Wr) and Halt_cntrl=0 SHALL capture Addr, Write_data and type, load counter with LATENCY-1, and go to BUSY (LATENCY=1: straight to DONE).
REQ-020 If Rd and Wr are both asserted, the block SHALL treat the request as a write.
REQ-021 BUSY SHALL decrement the counter each cycle and go to DONE when it reaches 0.
REQ-022 DONE SHALL assert Done for exactly one cycle, return to IDLE, and ignore requests present in that cycle.
REQ-023 Done SHALL be high exactly LATENCY cycles after the acceptance edge.
REQ-024 Stall SHALL be combinational: high in IDLE with a request accepted, high in BUSY, low in DONE, IDLE-without-request and HALT.
REQ-025 A read SHALL present mem[index] on Read_data in the DONE cycle and hold it until the next read completes; writes SHALL NOT change Read_data.
REQ-026 A write SHALL commit to storage on the edge leaving DONE; no earlier.
REQ-027 If index >= DEPTH, Err SHALL be 1 with Done, the write SHALL be suppressed, and Read_data SHALL become 0.
REQ-028 IDLE with Halt_cntrl=1 SHALL enter HALT; HALT SHALL be left only by rst.
REQ-029 Halt_cntrl asserted during BUSY/DONE SHALL let the access complete, then enter HALT instead of IDLE.
REQ-030 Halted SHALL be 1 exactly while in HALT; requests there SHALL be ignored and Stall SHALL be 0.

Reset
REQ-031 rst SHALL force IDLE, counter 0, Read_data 0, Done 0, Err 0, Halted 0, Stall 0 (absent request).
REQ-032 rst during BUSY/DONE SHALL abort the access with no storage write.
REQ-033 Storage contents SHALL NOT be cleared by rst.

Configuration
REQ-034 With MEM_ALIGN_CHECK_EN defined, Addr with nonzero low S bits SHALL be faulted exactly as REQ-027.
REQ-035 Without MEM_ALIGN_CHECK_EN, the low S bits SHALL be ignored and no alignment fault raised.

Verification
REQ-036 Write 0xBEEF to Addr 0x0010, then read 0x0010 (LATENCY=4) -> Done 4 cycles after each acceptance, Read_data=0xBEEF, Stall high 4 cycles per access.
REQ-037 Read and write both asserted at Addr 0x0020 with data 0x1234 -> treated as write; subsequent read returns 0x1234.
REQ-038 Read Addr 0x0800 (index 1024, DEPTH 1024) -> Err=1 with Done, Read_data=0; a write to the same address leaves storage unchanged.
REQ-039 Write to Addr 0x0030, rst pulsed in the 2nd BUSY cycle -> no Done; read of 0x0030 returns the prior value.
REQ-040 Halt_cntrl raised during a BUSY read -> read completes with Done, then Halted=1; a later request gives Stall=0 and no Done until rst.
REQ-041 Read Addr 0x0011 -> Err=1 with MEM_ALIGN_CHECK_EN; without it, Err=0 and data of word 0x0010 returned.
